// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Used by the IF stage and by the ID/hazard logic.
package pipe_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pcplus4;
    logic              valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:   NOP_INSTR,
    pcplus4: '0,
    valid:   1'b0
  };

endpackage

// File: rtl/pipe_ifid_reg.sv
// Pipeline register with reset, bubble-load and hold.
// Priority: reset > bubble > hold > load.
module pipe_ifid_reg
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // register update, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= IFID_BUBBLE;
    end else if (bubble) begin
      q <= IFID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: PC register, redirect mux, IF/ID.
// Optional hold/flush counters under FETCH_STATS_EN.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W    = pipe_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0]       NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCwrite,
  input  logic              IFIDwrite,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IFIDInstr,
  output logic [ADDR_W-1:0] IFIDPCplus4,
`ifdef FETCH_STATS_EN
  output logic [15:0]       hold_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              IFIDValid
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus4;
  logic              ifidBubble;
  ifid_t             ifidD;
  ifid_t             ifidQ;

  assign pcPlus4   = pc + ADDR_W'(4);
  assign imem_addr = pc;

  // PC register: reset > redirect > hold > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= {branch_target[ADDR_W-1:2], 2'b00};
    end else if (!PCwrite) begin
      pc <= pcPlus4;
    end
  end

  // held PC with free IF/ID loads a bubble, never a duplicate
  always_comb begin
    ifidBubble    = branch_taken | (PCwrite & ~IFIDwrite);
    ifidD.instr   = imem_rdata;
    ifidD.pcplus4 = pcPlus4;
    ifidD.valid   = 1'b1;
  end

  pipe_ifid_reg uIfid (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (IFIDwrite),
    .bubble (ifidBubble),
    .d      (ifidD),
    .q      (ifidQ)
  );

  assign IFIDInstr   = ifidQ.instr;
  assign IFIDPCplus4 = ifidQ.pcplus4;
  assign IFIDValid   = ifidQ.valid;

`ifdef FETCH_STATS_EN
  logic [15:0] holdCnt;
  logic [15:0] flushCnt;

  // saturating hold and flush counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdCnt  <= '0;
      flushCnt <= '0;
    end else begin
      if (PCwrite && !branch_taken && holdCnt != 16'hFFFF)
        holdCnt <= holdCnt + 16'd1;
      if (branch_taken && flushCnt != 16'hFFFF)
        flushCnt <= flushCnt + 16'd1;
    end
  end

  assign hold_cnt  = holdCnt;
  assign flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch.
// Stats checks run when FETCH_STATS_EN is defined.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCwrite;
  logic        IFIDwrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCplus4;
  logic        IFIDValid;
`ifdef FETCH_STATS_EN
  logic [15:0] hold_cnt;
  logic [15:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // memory model: mem[a] = 0x1000_0000 | a
  assign imem_rdata = 32'h1000_0000 | imem_addr;

  pipe_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCwrite       (PCwrite),
    .IFIDwrite     (IFIDwrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .IFIDInstr     (IFIDInstr),
    .IFIDPCplus4   (IFIDPCplus4),
`ifdef FETCH_STATS_EN
    .hold_cnt      (hold_cnt),
    .flush_cnt     (flush_cnt),
`endif
    .IFIDValid     (IFIDValid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCwrite       = 1'b0;
    IFIDwrite     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  task automatic doReset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got pc=%h ifid=%h/%h/%b want 0/0/0/0",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h4, 32'h1000_0000, 32'h4, 1'b1}) begin
      bad++;
      $display("FAIL first_fetch got pc=%h ifid=%h/%h/%b want 4/10000000/4/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] expP4   [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    doReset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_addr !== expAddr[i]) begin
        bad++;
        $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, expAddr[i]);
      end
      step();
      total++;
      if ({IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h1000_0000 | expAddr[i], expP4[i], 1'b1}) begin
        bad++;
        $display("FAIL seq_ifid%0d got %h/%h/%b want %h/%h/1", i,
                 IFIDInstr, IFIDPCplus4, IFIDValid, 32'h1000_0000 | expAddr[i], expP4[i]);
      end
    end
  endtask

  task automatic test_load_use_hold();
    doReset();
    step();
    step();
    PCwrite   = 1'b1;
    IFIDwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h8, 32'h1000_0004, 32'h8, 1'b1}) begin
        bad++;
        $display("FAIL hold%0d got pc=%h ifid=%h/%h/%b want 8/10000004/8/1", i,
                 imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
      end
    end
    idle();
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'hC, 32'h1000_0008, 32'hC, 1'b1}) begin
      bad++;
      $display("FAIL hold_release got pc=%h ifid=%h/%h/%b want c/10000008/c/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    step();
    idle();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL branch_bubble got pc=%h ifid=%h/%h/%b want 40/0/0/0",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h44, 32'h1000_0040, 32'h44, 1'b1}) begin
      bad++;
      $display("FAIL branch_target got pc=%h ifid=%h/%h/%b want 44/10000040/44/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_redirect_over_hold();
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    PCwrite       = 1'b1;
    IFIDwrite     = 1'b1;
    step();
    idle();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h80, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL redirect_wins got pc=%h ifid=%h/%h/%b want 80/0/0/0",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_split_hold();
    PCwrite = 1'b1;
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h80, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL split_pc_hold got pc=%h ifid=%h/%h/%b want 80/0/0/0",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
    idle();
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h84, 32'h1000_0080, 32'h84, 1'b1}) begin
      bad++;
      $display("FAIL split_resume got pc=%h ifid=%h/%h/%b want 84/10000080/84/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
    IFIDwrite = 1'b1;
    step();
    idle();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h88, 32'h1000_0080, 32'h84, 1'b1}) begin
      bad++;
      $display("FAIL split_ifid_hold got pc=%h ifid=%h/%h/%b want 88/10000080/84/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    idle();
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_target got %h want fffffffc", imem_addr);
    end
    step();
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL wrap_adv got pc=%h ifid=%h/%h/%b want 0/fffffffc/0/1",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

  task automatic test_reset_midstream();
    step();
    rst_n         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    idle();
    rst_n = 1'b1;
    total++;
    if ({imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got pc=%h ifid=%h/%h/%b want 0/0/0/0",
               imem_addr, IFIDInstr, IFIDPCplus4, IFIDValid);
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    doReset();
    total++;
    if ({hold_cnt, flush_cnt} !== 32'h0) begin
      bad++;
      $display("FAIL stats_reset got %h/%h want 0/0", hold_cnt, flush_cnt);
    end
    PCwrite = 1'b1;
    step();
    step();
    step();
    idle();
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    step();
    idle();
    total++;
    if ({hold_cnt, flush_cnt} !== {16'd3, 16'd1}) begin
      bad++;
      $display("FAIL stats_count got %h/%h want 3/1", hold_cnt, flush_cnt);
    end
    force dut.holdCnt = 16'hFFFF;
    #1;
    release dut.holdCnt;
    PCwrite = 1'b1;
    step();
    idle();
    total++;
    if (hold_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_sat got %h want ffff", hold_cnt);
    end
  endtask
`endif

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_load_use_hold();
    test_branch();
    test_redirect_over_hold();
    test_split_hold();
    test_wrap();
    test_reset_midstream();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address. It sits directly upstream of the `hazard` unit. It consumes that unit's `PCwrite`/`IFIDwrite` hold requests and feeds the hazard unit's IF/ID register-field inputs from `IFIDInstr`. It also accepts the branch redirect resolved downstream and squashes the wrong-path instruction.

## Interface
- `ADDR_W`, 32: PC / address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, 32'h0000_0000: bubble encoding (`sll $0,$0,0`).
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `PCwrite`  in  1  from `hazard`; 1 = hold PC (same polarity as the hazard unit drives it).
- `IFIDwrite`  in  1  from `hazard`; 1 = hold IF/ID.
- `branch_taken`  in  1  resolved taken branch/jump; redirect this cycle.
- `branch_target`  in  ADDR_W  redirect address.
- `imem_addr`  out  ADDR_W  equals the PC register (combinational from the flop).
- `imem_rdata`  in  32  instruction at `imem_addr`, combinational memory, same cycle.
- `IFIDInstr`  out  32  instruction latched in IF/ID. Bits [25:21]/[20:16] feed the hazard unit's Rs/Rt inputs.
- `IFIDPCplus4`  out  ADDR_W  PC+4 of the latched instruction.
- `IFIDValid`  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- `hold_cnt`  out  16  saturating hold-cycle count (only with `FETCH_STATS_EN`).
- `flush_cnt`  out  16  saturating flush count (only with `FETCH_STATS_EN`).

## Operation
- Reset values (when `rst_n`=0 at an edge):
  - PC = `RESET_PC`.
  - `IFIDInstr` = `NOP_INSTR`, `IFIDPCplus4` = 0, `IFIDValid` = 0.
  - Counters = 0.
- Per-edge priority: reset > redirect > hold > advance.
- Redirect (`branch_taken`=1):
  - PC ← `branch_target` with bits [1:0] forced to 0.
  - IF/ID ← bubble (`NOP_INSTR`, PCplus4 0, Valid 0).
  - Overrides `PCwrite`/`IFIDwrite` regardless of their values.
- PC hold (`PCwrite`=1): PC unchanged.
- IF/ID hold (`IFIDwrite`=1): IF/ID contents unchanged.
- Advance (both hold inputs 0):
  - PC ← PC+4, modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
  - IF/ID ← {`imem_rdata`, PC+4, Valid 1}.
- Split hold, `PCwrite`=1 with `IFIDwrite`=0: PC held; IF/ID loads a bubble. The current instruction must not be captured twice.
- Split hold, `PCwrite`=0 with `IFIDwrite`=1: PC advances; IF/ID held; the skipped fetch is lost. This is a legal but unused encoding; the bench must not flag it.
- No combinational path from `branch_taken`, `PCwrite` or `IFIDwrite` to any output.

## Timing
- Fetch latency is 1 cycle: the instruction at `imem_addr` during cycle N appears on `IFIDInstr` after edge N.
- Redirect:
  - Target on `imem_addr` the cycle after `branch_taken`.
  - Target instruction in IF/ID 2 cycles after `branch_taken`.
  - Exactly one bubble is inserted by this block; further squashing is the hazard unit's job.
- Hold: outputs are frozen for every cycle the hold is asserted. Advance resumes on the first edge with the hold deasserted.
- Reset mid-stream: takes effect on the next edge and discards all pending state.
- First edge after reset release fetches from `RESET_PC`.

## Configuration
- `FETCH_STATS_EN` defined:
  - `hold_cnt` increments on each non-reset edge with `PCwrite`=1 and `branch_taken`=0.
  - `flush_cnt` increments on each edge with `branch_taken`=1.
  - Both counters saturate at 0xFFFF.
- Not defined: both ports and counters are absent; no logic is generated.

## Structure
- Package `pipe_pkg`: `NOP_INSTR`, the default `RESET_PC`, the `ADDR_W` constant, and an `ifid_t` struct {instr, pcplus4, valid}. It is shared with ID/hazard.
- Sub-module `pipe_ifid_reg`: the IF/ID register with hold, bubble-load and reset. It is reusable for the ID/EX-style registers.
- The PC register, adder and priority mux live in the top module.

## Test plan
- Reset: `rst_n`=0 for 2 edges → PC=0, `IFIDInstr`=0, `IFIDValid`=0. First edge after release → IF/ID={mem[0],4,1}, PC=4.
- Sequential fetch: 4 free edges → `imem_addr` 0,4,8,12; `IFIDPCplus4` 4,8,12,16, lagging one cycle.
- Load-use hold: `PCwrite`=`IFIDwrite`=1 for 2 cycles at PC=8 → PC stays 8, IF/ID keeps {mem[4],8,1}. On release → IF/ID={mem[8],12,1}, PC=12.
- Branch: `branch_taken`=1, target 0x43 at PC=12:
  - Next edge → PC=0x40, IFIDValid=0, IFIDInstr=NOP.
  - Following edge → IF/ID={mem[0x40],0x44,1}.
- Simultaneous redirect + hold, plus wrap:
  - `branch_taken`=1 with `PCwrite`=1, target 0x80 → PC=0x80 and a bubble (redirect wins).
  - Separately, PC=0xFFFF_FFFC advance → PC=0.
- `FETCH_STATS_EN`:
  - 3 hold cycles + 1 redirect → `hold_cnt`=3, `flush_cnt`=1.
  - Preload 0xFFFF by forcing the counter, then one more hold → `hold_cnt` stays 0xFFFF.
